// File: rtl/dma_cmd_arbiter.sv
// Purpose : round-robin arbiter that merges the write and read command channels onto one DMA command port.
// Latency : one registered stage; a command accepted upstream is valid on cmd_* the following cycle.
// Backpres: the output register only reloads when empty or taken (cmd_ready); while stalled both upstream readies stay low.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   wr_cmd_* / rd_cmd_*             upstream write / read command channels (valid/ready)
//   cmd_*                           merged command towards the encoder (valid/ready)
//   wr_rsp_done, rd_rsp_done        completion pulses that return one credit each
//   hold                            context update in progress: no new grants
//   wr_outstanding, rd_outstanding  outstanding-command counters
//   idle, cnt_err                   drained indication, sticky credit underflow flag
module dma_cmd_arbiter #(
    parameter int MAX_OUT_W = 32,
    parameter int MAX_OUT_R = 32,
    parameter int BURST     = 4,
    parameter int CNTW      = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_cmd_valid,
    output logic            wr_cmd_ready,
    input  logic [1023:0]   wr_cmd_data,
    input  logic [127:0]    wr_cmd_be,
    input  logic [63:0]     wr_cmd_ea,
    input  logic [5:0]      wr_cmd_tag,
    input  logic            rd_cmd_valid,
    output logic            rd_cmd_ready,
    input  logic [127:0]    rd_cmd_be,
    input  logic [63:0]     rd_cmd_ea,
    input  logic [5:0]      rd_cmd_tag,
    output logic            cmd_valid,
    input  logic            cmd_ready,
    output logic            cmd_is_read,
    output logic [1023:0]   cmd_data,
    output logic [127:0]    cmd_be,
    output logic [63:0]     cmd_ea,
    output logic [5:0]      cmd_tag,
    input  logic            wr_rsp_done,
    input  logic            rd_rsp_done,
    input  logic            hold,
    output logic [CNTW-1:0] wr_outstanding,
    output logic [CNTW-1:0] rd_outstanding,
    output logic            idle,
    output logic            cnt_err
);

    localparam int              BW      = $clog2(BURST + 1);
    localparam logic [CNTW-1:0] MAX_W   = CNTW'(MAX_OUT_W);
    localparam logic [CNTW-1:0] MAX_R   = CNTW'(MAX_OUT_R);
    localparam logic [BW-1:0]   BURST_V = BW'(BURST);

    typedef enum logic {OWN_W = 1'b0, OWN_R = 1'b1} own_t;
    typedef enum logic [1:0] {PICK_NONE = 2'd0, PICK_W = 2'd1, PICK_R = 2'd2} pick_t;

    own_t            own_q, own_d;
    logic [BW-1:0]   burst_q, burst_d;
    logic            cmd_valid_q;
    logic            is_read_q;
    logic [1023:0]   data_q;
    logic [127:0]    be_q;
    logic [63:0]     ea_q;
    logic [5:0]      tag_q;
    logic [CNTW-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNTW-1:0] rd_cnt_q, rd_cnt_d;
    logic            err_q;
    logic            wr_err, rd_err;

    logic  elig_w, elig_r, cur_elig, oth_elig;
    logic  load, accept;
    pick_t pick, cur_pick, oth_pick;

    // Credit counter update: increment and decrement together cancel; a
    // decrement with nothing outstanding saturates at zero and flags an error.
    function automatic logic [CNTW:0] cnt_upd(input logic [CNTW-1:0] cnt,
                                              input logic inc, input logic dec);
        logic [CNTW:0] r;
        r = {1'b0, cnt};
        if (inc && !dec) begin
            r = {1'b0, cnt + CNTW'(1)};
        end else if (dec && !inc) begin
            if (cnt == '0) r = {1'b1, cnt};
            else           r = {1'b0, cnt - CNTW'(1)};
        end
        return r;
    endfunction

    always_comb begin
        elig_w   = wr_cmd_valid && !hold && (wr_cnt_q < MAX_W);
        elig_r   = rd_cmd_valid && !hold && (rd_cnt_q < MAX_R);
        cur_elig = (own_q == OWN_W) ? elig_w : elig_r;
        oth_elig = (own_q == OWN_W) ? elig_r : elig_w;
        cur_pick = (own_q == OWN_W) ? PICK_W : PICK_R;
        oth_pick = (own_q == OWN_W) ? PICK_R : PICK_W;

        // Owner keeps the port up to BURST grants; the other channel gets it
        // next if eligible, otherwise the owner continues on a fresh burst.
        pick = PICK_NONE;
        if (cur_elig && (burst_q < BURST_V)) pick = cur_pick;
        else if (oth_elig)                   pick = oth_pick;
        else if (cur_elig)                   pick = cur_pick;
    end

    assign load = !cmd_valid_q || cmd_ready;

    // Readies are masked during reset so upstream never sees a handshake for
    // a command that the reset is about to drop.
    assign wr_cmd_ready = !rst && load && (pick == PICK_W);
    assign rd_cmd_ready = !rst && load && (pick == PICK_R);
    assign accept       = wr_cmd_ready || rd_cmd_ready;

    always_comb begin
        own_d   = own_q;
        burst_d = burst_q;
        if (accept) begin
            own_d   = (pick == PICK_R) ? OWN_R : OWN_W;
            burst_d = ((pick == cur_pick) && (burst_q < BURST_V)) ? burst_q + BW'(1) : BW'(1);
        end
        {wr_err, wr_cnt_d} = cnt_upd(wr_cnt_q, wr_cmd_valid && wr_cmd_ready, wr_rsp_done);
        {rd_err, rd_cnt_d} = cnt_upd(rd_cnt_q, rd_cmd_valid && rd_cmd_ready, rd_rsp_done);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            own_q       <= OWN_W;
            burst_q     <= '0;
            cmd_valid_q <= 1'b0;
            is_read_q   <= 1'b0;
            data_q      <= '0;
            be_q        <= '0;
            ea_q        <= '0;
            tag_q       <= '0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            own_q    <= own_d;
            burst_q  <= burst_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            err_q    <= err_q | wr_err | rd_err;
            // Fields only change on a reload, so a stalled command is stable.
            if (load) begin
                cmd_valid_q <= accept;
                if (accept) begin
                    is_read_q <= (pick == PICK_R);
                    data_q    <= (pick == PICK_R) ? '0 : wr_cmd_data;
                    be_q      <= (pick == PICK_R) ? rd_cmd_be  : wr_cmd_be;
                    ea_q      <= (pick == PICK_R) ? rd_cmd_ea  : wr_cmd_ea;
                    tag_q     <= (pick == PICK_R) ? rd_cmd_tag : wr_cmd_tag;
                end
            end
        end
    end

    assign cmd_valid      = cmd_valid_q;
    assign cmd_is_read    = is_read_q;
    assign cmd_data       = data_q;
    assign cmd_be         = be_q;
    assign cmd_ea         = ea_q;
    assign cmd_tag        = tag_q;
    assign wr_outstanding = wr_cnt_q;
    assign rd_outstanding = rd_cnt_q;
    assign idle           = !cmd_valid_q && (wr_cnt_q == '0) && (rd_cnt_q == '0);
    assign cnt_err        = err_q;

endmodule

// File: tb/tb_dma_cmd_arbiter.sv
// Purpose : directed bench for dma_cmd_arbiter; a default-sized instance plus one with a 2-deep write credit pool.
// Latency : inputs are driven 1 time unit after posedge, readies sampled 1 unit later, registers 1 unit after the next posedge.
// Backpres: cmd_ready is driven directly by the stimulus.
module tb_dma_cmd_arbiter;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_cmd_valid, rd_cmd_valid, cmd_ready;
    logic [1023:0] wr_cmd_data;
    logic [127:0]  wr_cmd_be, rd_cmd_be;
    logic [63:0]   wr_cmd_ea, rd_cmd_ea;
    logic [5:0]    wr_cmd_tag, rd_cmd_tag;
    logic          wr_rsp_done, rd_rsp_done, hold;

    logic          wr_cmd_ready, rd_cmd_ready, cmd_valid, cmd_is_read, idle, cnt_err;
    logic [1023:0] cmd_data;
    logic [127:0]  cmd_be;
    logic [63:0]   cmd_ea;
    logic [5:0]    cmd_tag, wr_outstanding, rd_outstanding;

    logic          s_wr_rdy, s_rd_rdy, s_cmd_valid, s_is_read, s_idle, s_cnt_err;
    logic [1023:0] s_data;
    logic [127:0]  s_be;
    logic [63:0]   s_ea;
    logic [5:0]    s_tag, s_wr_out, s_rd_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dma_cmd_arbiter u_dut (
        .clk(clk), .rst(rst),
        .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready), .wr_cmd_data(wr_cmd_data),
        .wr_cmd_be(wr_cmd_be), .wr_cmd_ea(wr_cmd_ea), .wr_cmd_tag(wr_cmd_tag),
        .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready), .rd_cmd_be(rd_cmd_be),
        .rd_cmd_ea(rd_cmd_ea), .rd_cmd_tag(rd_cmd_tag),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_is_read(cmd_is_read),
        .cmd_data(cmd_data), .cmd_be(cmd_be), .cmd_ea(cmd_ea), .cmd_tag(cmd_tag),
        .wr_rsp_done(wr_rsp_done), .rd_rsp_done(rd_rsp_done), .hold(hold),
        .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding),
        .idle(idle), .cnt_err(cnt_err)
    );

    dma_cmd_arbiter #(.MAX_OUT_W(2)) u_small (
        .clk(clk), .rst(rst),
        .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(s_wr_rdy), .wr_cmd_data(wr_cmd_data),
        .wr_cmd_be(wr_cmd_be), .wr_cmd_ea(wr_cmd_ea), .wr_cmd_tag(wr_cmd_tag),
        .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(s_rd_rdy), .rd_cmd_be(rd_cmd_be),
        .rd_cmd_ea(rd_cmd_ea), .rd_cmd_tag(rd_cmd_tag),
        .cmd_valid(s_cmd_valid), .cmd_ready(cmd_ready), .cmd_is_read(s_is_read),
        .cmd_data(s_data), .cmd_be(s_be), .cmd_ea(s_ea), .cmd_tag(s_tag),
        .wr_rsp_done(wr_rsp_done), .rd_rsp_done(rd_rsp_done), .hold(hold),
        .wr_outstanding(s_wr_out), .rd_outstanding(s_rd_out),
        .idle(s_idle), .cnt_err(s_cnt_err)
    );

    typedef struct packed {
        logic       wv, rv, hd, cr, wd, rdn;  // stimulus
        logic       e_wrdy, e_rrdy;           // readies in the same cycle
        logic       e_cv, e_ird;              // cmd_valid / cmd_is_read after the edge
        logic [5:0] e_wo, e_ro;               // counters after the edge
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(input logic wv, rv, hd, cr, wd, rdn,
                                input logic ewr, err, ecv, eird, input int ewo, ero);
        vec_t v;
        v.wv = wv; v.rv = rv; v.hd = hd; v.cr = cr; v.wd = wd; v.rdn = rdn;
        v.e_wrdy = ewr; v.e_rrdy = err; v.e_cv = ecv; v.e_ird = eird;
        v.e_wo = 6'(ewo); v.e_ro = 6'(ero);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wr_cmd_valid = 0; rd_cmd_valid = 0; cmd_ready = 1; hold = 0;
        wr_rsp_done = 0; rd_rsp_done = 0;
    endtask

    // Leaves time at posedge+1 with reset applied at the preceding edge.
    task automatic do_reset();
        idle_inputs();
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        int nw, nz, nv;
        logic [1023:0] expd;

        // grant sequence WWWW RRRR W, then hold, drain, done pulses, stall
        tbl[0]  = mk(1,1,0,1,0,0, 1,0,1,0, 1,0);
        tbl[1]  = mk(1,1,0,1,0,0, 1,0,1,0, 2,0);
        tbl[2]  = mk(1,1,0,1,0,0, 1,0,1,0, 3,0);
        tbl[3]  = mk(1,1,0,1,0,0, 1,0,1,0, 4,0);
        tbl[4]  = mk(1,1,0,1,0,0, 0,1,1,1, 4,1);
        tbl[5]  = mk(1,1,0,1,0,0, 0,1,1,1, 4,2);
        tbl[6]  = mk(1,1,0,1,0,0, 0,1,1,1, 4,3);
        tbl[7]  = mk(1,1,0,1,0,0, 0,1,1,1, 4,4);
        tbl[8]  = mk(1,1,0,1,0,0, 1,0,1,0, 5,4);
        tbl[9]  = mk(1,1,1,1,0,0, 0,0,0,0, 5,4);
        tbl[10] = mk(1,1,1,1,1,0, 0,0,0,0, 4,4);
        tbl[11] = mk(1,1,1,1,0,1, 0,0,0,0, 4,3);
        tbl[12] = mk(1,0,0,1,1,0, 1,0,1,0, 4,3);
        tbl[13] = mk(0,1,0,0,0,0, 0,0,1,0, 4,3);
        tbl[14] = mk(0,1,0,1,0,0, 0,1,1,1, 4,4);
        tbl[15] = mk(0,0,0,1,0,0, 0,0,0,1, 4,4);

        wr_cmd_data = '0; wr_cmd_be = '1; wr_cmd_ea = 64'h1000; wr_cmd_tag = 6'd1;
        rd_cmd_be = 128'hF0F0; rd_cmd_ea = 64'h2000; rd_cmd_tag = 6'd2;
        idle_inputs();
        rst = 1;
        tick(); tick();

        // ---- reset state (fields loaded from a dirty register first)
        rst = 0;
        wr_cmd_valid = 1; wr_cmd_data = '1;
        tick();
        do_reset();
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_is_read", cmd_is_read, 0);
        chk("rst_data", (cmd_data === '0), 1);
        chk("rst_be", (cmd_be === '0), 1);
        chk("rst_ea", cmd_ea, 0);
        chk("rst_tag", cmd_tag, 0);
        chk("rst_wr_out", wr_outstanding, 0);
        chk("rst_rd_out", rd_outstanding, 0);
        chk("rst_cnt_err", cnt_err, 0);

        // ---- table: arbitration order, hold, simultaneous accept+done, stall
        wr_cmd_data = {16{64'hCAFE_0000_0000_BEEF}};
        for (int i = 0; i < 16; i++) begin
            wr_cmd_valid = tbl[i].wv; rd_cmd_valid = tbl[i].rv; hold = tbl[i].hd;
            cmd_ready = tbl[i].cr; wr_rsp_done = tbl[i].wd; rd_rsp_done = tbl[i].rdn;
            #1;
            chk($sformatf("tbl%0d_wr_ready", i), wr_cmd_ready, tbl[i].e_wrdy);
            chk($sformatf("tbl%0d_rd_ready", i), rd_cmd_ready, tbl[i].e_rrdy);
            tick();
            chk($sformatf("tbl%0d_cmd_valid", i), cmd_valid, tbl[i].e_cv);
            chk($sformatf("tbl%0d_is_read", i), cmd_is_read, tbl[i].e_ird);
            chk($sformatf("tbl%0d_wr_out", i), wr_outstanding, tbl[i].e_wo);
            chk($sformatf("tbl%0d_rd_out", i), rd_outstanding, tbl[i].e_ro);
        end

        // ---- 10 back-to-back writes, write channel only
        do_reset();
        nv = 0;
        for (int i = 0; i < 10; i++) begin
            wr_cmd_valid = 1;
            wr_cmd_ea    = 64'h4000 + 64'(i);
            wr_cmd_tag   = 6'(i);
            wr_cmd_data  = {16{64'hD0D0_0000_0000_0000 + 64'(i)}};
            #1;
            chk($sformatf("b2b%0d_wr_ready", i), wr_cmd_ready, 1);
            chk($sformatf("b2b%0d_rd_ready", i), rd_cmd_ready, 0);
            tick();
            expd = {16{64'hD0D0_0000_0000_0000 + 64'(i)}};
            if (cmd_valid) nv++;
            chk($sformatf("b2b%0d_ea", i), cmd_ea, 64'h4000 + 64'(i));
            chk($sformatf("b2b%0d_tag", i), cmd_tag, 64'(i));
            chk($sformatf("b2b%0d_is_read", i), cmd_is_read, 0);
            chk($sformatf("b2b%0d_data", i), (cmd_data === expd), 1);
        end
        wr_cmd_valid = 0;
        chk("b2b_valid_cycles", nv, 10);
        chk("b2b_wr_out", wr_outstanding, 10);
        tick();
        chk("b2b_drained", cmd_valid, 0);

        // ---- read stalled in the register for 5 cycles
        do_reset();
        rd_cmd_valid = 1; rd_cmd_ea = 64'hA0; rd_cmd_tag = 6'd5;
        wr_cmd_data = '1;
        #1;
        chk("bp_first_rd_ready", rd_cmd_ready, 1);
        tick();
        chk("bp_first_valid", cmd_valid, 1);
        chk("bp_first_is_read", cmd_is_read, 1);
        chk("bp_first_data_zero", (cmd_data === '0), 1);
        chk("bp_first_be", cmd_be[63:0], 64'hF0F0);
        cmd_ready = 0; rd_cmd_ea = 64'hB0; rd_cmd_tag = 6'd6; wr_cmd_valid = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("bp%0d_wr_ready", i), wr_cmd_ready, 0);
            chk($sformatf("bp%0d_rd_ready", i), rd_cmd_ready, 0);
            tick();
            chk($sformatf("bp%0d_valid", i), cmd_valid, 1);
            chk($sformatf("bp%0d_ea", i), cmd_ea, 64'hA0);
            chk($sformatf("bp%0d_tag", i), cmd_tag, 5);
        end
        cmd_ready = 1;
        #1;
        chk("bp_release_rd_ready", rd_cmd_ready, 1);
        tick();
        chk("bp_release_ea", cmd_ea, 64'hB0);
        chk("bp_release_tag", cmd_tag, 6);
        idle_inputs();

        // ---- write credit limit of 2 on the small instance
        do_reset();
        wr_cmd_valid = 1; rd_cmd_valid = 1;
        nw = 0; nz = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (s_wr_rdy) nw++;
            if (!s_wr_rdy && !s_rd_rdy) nz++;
            tick();
        end
        chk("lim_writes", nw, 2);
        chk("lim_wr_out", s_wr_out, 2);
        chk("lim_no_bubble", nz, 0);
        nw = 0;
        for (int i = 0; i < 10; i++) begin
            wr_rsp_done = (i == 0);
            #1;
            if (s_wr_rdy) nw++;
            if (!s_wr_rdy && !s_rd_rdy) nz++;
            tick();
        end
        wr_rsp_done = 0;
        chk("lim_writes_after_done", nw, 1);
        chk("lim_wr_out_after_done", s_wr_out, 2);
        chk("lim_no_bubble2", nz, 0);
        chk("lim_valid", s_cmd_valid, 1);
        idle_inputs();

        // ---- hold with 3 outstanding writes, then 3 done pulses
        do_reset();
        wr_cmd_valid = 1;
        tick(); tick(); tick();
        hold = 1; rd_cmd_valid = 1;
        #1;
        chk("hold_wr_ready", wr_cmd_ready, 0);
        chk("hold_rd_ready", rd_cmd_ready, 0);
        tick();
        chk("hold_drained", cmd_valid, 0);
        chk("hold_wr_out", wr_outstanding, 3);
        chk("hold_not_idle", idle, 0);
        for (int i = 0; i < 3; i++) begin
            wr_rsp_done = 1;
            #1;
            chk($sformatf("hold_done%0d_ready", i), wr_cmd_ready | rd_cmd_ready, 0);
            tick();
            chk($sformatf("hold_done%0d_wr_out", i), wr_outstanding, 64'(2 - i));
        end
        wr_rsp_done = 0;
        chk("hold_idle", idle, 1);
        chk("hold_valid", cmd_valid, 0);
        idle_inputs();

        // ---- credit underflow is sticky; reset mid-stream
        do_reset();
        rd_rsp_done = 1;
        tick();
        rd_rsp_done = 0;
        chk("err_rd_out", rd_outstanding, 0);
        chk("err_set", cnt_err, 1);
        tick(); tick(); tick();
        chk("err_sticky", cnt_err, 1);
        wr_cmd_valid = 1;
        tick(); tick();
        chk("mid_valid", cmd_valid, 1);
        chk("mid_wr_out", wr_outstanding, 2);
        chk("mid_err_still", cnt_err, 1);
        rst = 1;
        tick();
        chk("mid_rst_valid", cmd_valid, 0);
        chk("mid_rst_wr_out", wr_outstanding, 0);
        chk("mid_rst_err", cnt_err, 0);
        rst = 0;
        idle_inputs();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dma_cmd_arbiter.md
Name: dma_cmd_arbiter

Overview:
- Shares one DMA command port between the data bridge write channel and read channel.
- Arbitration is round-robin with a burst weight. Each channel has its own outstanding-command credit limit.
- New grants are held off while a context update is in progress.
- Sits between the data bridge command outputs and the command encoder. Gives one registered command stage with a 1-cycle accept-to-valid latency.

Parameters:
- MAX_OUT_W, 32, maximum outstanding write commands (1..2^CNTW-1).
- MAX_OUT_R, 32, maximum outstanding read commands (1..2^CNTW-1).
- BURST, 4, maximum consecutive grants to one channel while the other is eligible (>=1).
- CNTW, 6, width of the outstanding counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- wr_cmd_valid  in  1  write channel command valid
- wr_cmd_ready  out  1  write channel command accepted
- wr_cmd_data  in  1024  write data
- wr_cmd_be  in  128  write byte enables
- wr_cmd_ea  in  64  write effective address
- wr_cmd_tag  in  6  write tag
- rd_cmd_valid  in  1  read channel command valid
- rd_cmd_ready  out  1  read channel command accepted
- rd_cmd_be  in  128  read byte enables
- rd_cmd_ea  in  64  read effective address
- rd_cmd_tag  in  6  read tag
- cmd_valid  out  1  merged command valid
- cmd_ready  in  1  downstream accepts the merged command
- cmd_is_read  out  1  1 = read command, 0 = write command
- cmd_data  out  1024  write data; all zero for reads
- cmd_be  out  128  byte enables
- cmd_ea  out  64  effective address
- cmd_tag  out  6  tag
- wr_rsp_done  in  1  pulse: one write command completed
- rd_rsp_done  in  1  pulse: one read command completed
- hold  in  1  context_update_ongoing; blocks new grants
- wr_outstanding  out  CNTW  current write credit count
- rd_outstanding  out  CNTW  current read credit count
- idle  out  1  no valid output and both counters zero
- cnt_err  out  1  sticky: a done pulse arrived while the matching counter was 0

Behaviour:
- Reset (rst=1 at a clk edge): all outputs 0 on the next cycle, including cmd_* fields, counters, cnt_err and burst_cnt. FSM goes to OWN_W.
- Load condition: load = !cmd_valid || cmd_ready.
- Eligibility: elig_w = wr_cmd_valid && !hold && wr_outstanding < MAX_OUT_W. elig_r is the same using rd_* signals and MAX_OUT_R.
- FSM has two states, OWN_W and OWN_R (cur = owner). burst_cnt is 0..BURST.
- Combinational pick, in priority order:
  - cur eligible and burst_cnt < BURST -> cur;
  - else other eligible -> other;
  - else cur eligible -> cur, and burst_cnt restarts;
  - else none.
- Readies: wr_cmd_ready = load && pick==W. rd_cmd_ready = load && pick==R. At most one is high per cycle. Readies depend on *_valid; there is no comb path from cmd_ready to anything except the readies.
- On accept:
  - the output register loads the picked command and cmd_valid=1 on the next cycle;
  - owner <= pick;
  - burst_cnt <= (pick==cur && burst_cnt<BURST) ? burst_cnt+1 : 1.
- No accept: owner and burst_cnt hold. If load && no pick, cmd_valid <= 0.
- While cmd_valid && !cmd_ready, all cmd_* outputs stay stable.
- Read command: cmd_data <= 0 and cmd_is_read <= 1.
- Counters:
  - increment on the upstream handshake (*_cmd_valid && *_cmd_ready);
  - decrement on *_rsp_done;
  - both in the same cycle -> unchanged;
  - done with counter 0 and no increment -> counter stays 0 and cnt_err <= 1. cnt_err clears only on rst.
- Full: counter == MAX -> that channel is ineligible. The other channel keeps being served with no burst limit.
- hold:
  - blocks new picks from the cycle it is sampled high;
  - an already-registered cmd still drains;
  - done pulses still decrement the counters;
  - idle goes 1 once drained.
- Reset mid-operation: a pending output command is dropped and the counters are zeroed. Upstream is responsible for re-issuing.

Test Plan:
- Only write channel, 10 back-to-back commands, cmd_ready=1: -> 10 cmd_valid cycles with is_read=0, first output 1 cycle after first accept; wr_outstanding=10; rd_cmd_ready never 1.
- Both channels continuously valid, BURST=4: -> grant order WWWW RRRR WWWW…, with no bubble cycles on cmd_valid.
- MAX_OUT_W=2, no wr_rsp_done, both valid: -> exactly 2 writes accepted, then only reads. A single wr_rsp_done pulse allows exactly 1 more write.
- cmd_ready held 0 for 5 cycles with a read in the register: -> cmd_ea/cmd_tag stable, both readies 0. On release, the next command appears the following cycle.
- hold=1 with 3 outstanding writes, then 3 wr_rsp_done pulses: -> no new grants, counter 3→0, idle=1. Simultaneous accept and done leaves the counter unchanged.
- rd_rsp_done with rd_outstanding=0: -> counter stays 0 and cnt_err=1 until rst. An rst pulse mid-stream zeroes cmd_valid and the counters on the next cycle.
